// File: rtl/window_feeder.sv
// Serial-to-window front end: collects signed samples into 9-sample windows
// and presents each window as a parallel bus together with its exact sum.
module window_feeder #(
   parameter int SLIDE = 0,
   parameter int DW    = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [9*DW-1:0] win,
   output logic [DW+3:0]   win_sum,
   output logic [3:0]      fill_cnt
);

   localparam int SW = DW + 4;

   typedef enum logic {O_EMPTY, O_FULL} ostate_t;

   function automatic logic signed [SW-1:0] sext(input logic signed [DW-1:0] x);
      return {{(SW-DW){x[DW-1]}}, x};
   endfunction

   logic signed [DW-1:0] sr_q [9];
   logic signed [DW-1:0] sr_d [9];
   logic signed [DW-1:0] shift_w [9];
   logic signed [SW-1:0] sum_q, sum_d, sum_upd, evict;
   logic [3:0]           fill_q, fill_d;
   logic [9*DW-1:0]      win_q, win_d, win_new;
   logic signed [SW-1:0] wsum_q, wsum_d;
   ostate_t              ost_q, ost_d;
   logic signed [DW-1:0] din;
   logic                 armed, accept, complete;

   assign din      = in_data;
   assign armed    = (fill_q == 4'd8);
   // A stalled window only blocks the sample that would overwrite it.
   assign in_ready = ~flush & ~((ost_q == O_FULL) & ~out_ready & armed);
   assign accept   = in_valid & in_ready;
   assign complete = accept & armed;

   always_comb begin
      for (int k = 0; k < 8; k++) shift_w[k] = sr_q[k+1];
      shift_w[8] = din;
      for (int k = 0; k < 9; k++) win_new[k*DW +: DW] = shift_w[k];
      // In block mode slot 0 belongs to the previous window, never to the running sum.
      evict   = (SLIDE != 0) ? sext(sr_q[0]) : '0;
      sum_upd = sum_q + sext(din) - evict;
   end

   always_comb begin
      sr_d   = sr_q;
      sum_d  = sum_q;
      fill_d = fill_q;
      win_d  = win_q;
      wsum_d = wsum_q;
      if (flush) begin
         for (int k = 0; k < 9; k++) sr_d[k] = '0;
         sum_d  = '0;
         fill_d = 4'd0;
      end else if (accept) begin
         sr_d = shift_w;
         if (complete) begin
            win_d  = win_new;
            wsum_d = sum_upd;
            fill_d = (SLIDE != 0) ? 4'd8 : 4'd0;
            sum_d  = (SLIDE != 0) ? sum_upd : '0;
         end else begin
            fill_d = fill_q + 4'd1;
            sum_d  = sum_upd;
         end
      end
   end

   always_comb begin
      ost_d = ost_q;
      if (complete)
         ost_d = O_FULL;
      else if ((ost_q == O_FULL) && out_ready)
         ost_d = O_EMPTY;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 9; k++) sr_q[k] <= '0;
         sum_q  <= '0;
         fill_q <= 4'd0;
         win_q  <= '0;
         wsum_q <= '0;
         ost_q  <= O_EMPTY;
      end else begin
         sr_q   <= sr_d;
         sum_q  <= sum_d;
         fill_q <= fill_d;
         win_q  <= win_d;
         wsum_q <= wsum_d;
         ost_q  <= ost_d;
      end
   end

   assign out_valid = (ost_q == O_FULL);
   assign win       = win_q;
   assign win_sum   = wsum_q;
   assign fill_cnt  = fill_q;

endmodule

// File: tb/tb_window_feeder.sv
// Directed bench for window_feeder: a block-mode and a sliding-mode instance
// share the input stimulus; each scenario checks the relevant instance.
module tb_window_feeder;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [5:0]  in_data;

   logic        b_in_ready, b_out_valid;
   logic [53:0] b_win;
   logic [9:0]  b_sum;
   logic [3:0]  b_fill;

   logic        s_in_ready, s_out_valid;
   logic [53:0] s_win;
   logic [9:0]  s_sum;
   logic [3:0]  s_fill;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   window_feeder #(.SLIDE(0), .DW(6)) u_blk (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .win(b_win), .win_sum(b_sum), .fill_cnt(b_fill)
   );

   window_feeder #(.SLIDE(1), .DW(6)) u_sld (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .win(s_win), .win_sum(s_sum), .fill_cnt(s_fill)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [5:0] v);
      in_valid = 1'b1;
      in_data  = v;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      #1;
      chk("rst_out_valid", b_out_valid, 0);
      chk("rst_fill", b_fill, 0);
      chk("rst_win", b_win, 0);
      chk("rst_sum", b_sum, 0);
      chk("rst_in_ready", b_in_ready, 1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // block mode, 1..9
      for (int i = 1; i <= 8; i++) send(6'(i));
      chk("blk_no_early_valid", b_out_valid, 0);
      chk("blk_fill8", b_fill, 8);
      send(6'd9);
      chk("blk_valid", b_out_valid, 1);
      chk("blk_win", b_win, {6'd9, 6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1});
      chk("blk_sum45", b_sum, 10'd45);
      chk("blk_fill0", b_fill, 0);
      step();
      chk("blk_valid_drop", b_out_valid, 0);

      // extremes
      for (int i = 0; i < 9; i++) send(6'h20);
      chk("min_sum", b_sum, 10'h2E0);
      chk("min_win", b_win, {9{6'h20}});
      for (int i = 0; i < 9; i++) send(6'h1F);
      chk("max_sum", b_sum, 10'h117);
      chk("max_win", b_win, {9{6'h1F}});
      step();

      // backpressure
      for (int i = 1; i <= 9; i++) send(6'(i));
      chk("bp_first_sum", b_sum, 10'd45);
      out_ready = 1'b0;
      for (int i = 10; i <= 17; i++) send(6'(i));
      chk("bp_fill8", b_fill, 8);
      chk("bp_hold_valid", b_out_valid, 1);
      chk("bp_hold_sum", b_sum, 10'd45);
      chk("bp_hold_win", b_win, {6'd9, 6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1});
      in_valid = 1'b1;
      in_data  = 6'd18;
      #1;
      chk("bp_in_ready_low", b_in_ready, 0);
      step();
      chk("bp_still_fill8", b_fill, 8);
      chk("bp_still_sum45", b_sum, 10'd45);
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("bp_b2b_valid", b_out_valid, 1);
      chk("bp_sum126", b_sum, 10'd126);
      chk("bp_win2", b_win, {6'd18, 6'd17, 6'd16, 6'd15, 6'd14, 6'd13, 6'd12, 6'd11, 6'd10});
      step();
      chk("bp_drop", b_out_valid, 0);

      // flush
      for (int i = 0; i < 5; i++) send(6'd7);
      chk("fl_fill5", b_fill, 5);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 6'd5;
      #1;
      chk("fl_in_ready_low", b_in_ready, 0);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_fill0", b_fill, 0);
      chk("fl_keep_sum", b_sum, 10'd126);
      for (int i = 0; i < 9; i++) send(6'd2);
      chk("fl_valid", b_out_valid, 1);
      chk("fl_sum18", b_sum, 10'd18);
      chk("fl_win", b_win, {9{6'd2}});

      // async reset mid-cycle
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(6'd1);
      chk("ar_pre_valid", b_out_valid, 1);
      #2 reset = 1'b1;
      #1;
      chk("ar_valid0", b_out_valid, 0);
      chk("ar_win0", b_win, 0);
      chk("ar_sum0", b_sum, 0);
      chk("ar_fill0", b_fill, 0);
      #1 reset = 1'b0;
      out_ready = 1'b1;
      step();
      for (int i = 0; i < 8; i++) send(6'd1);
      chk("ar_no_early_valid", b_out_valid, 0);
      send(6'd1);
      chk("ar_valid", b_out_valid, 1);
      chk("ar_sum9", b_sum, 10'd9);
      chk("ar_win", b_win, {9{6'd1}});

      // sliding mode
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      for (int i = 1; i <= 8; i++) send(6'(i));
      chk("sl_fill8", s_fill, 8);
      chk("sl_no_early_valid", s_out_valid, 0);
      send(6'd9);
      chk("sl_v1", s_out_valid, 1);
      chk("sl_sum45", s_sum, 10'd45);
      send(6'd10);
      chk("sl_v2", s_out_valid, 1);
      chk("sl_sum54", s_sum, 10'd54);
      send(6'd11);
      chk("sl_v3", s_out_valid, 1);
      chk("sl_sum63", s_sum, 10'd63);
      send(6'd12);
      chk("sl_v4", s_out_valid, 1);
      chk("sl_sum72", s_sum, 10'd72);
      chk("sl_slot0", s_win[5:0], 6'd4);
      chk("sl_win", s_win, {6'd12, 6'd11, 6'd10, 6'd9, 6'd8, 6'd7, 6'd6, 6'd5, 6'd4});
      chk("sl_fill_sat", s_fill, 8);
      step();
      chk("sl_drop", s_out_valid, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
